// File: rtl/cpu_pkg.sv
// Shared types and constants for the cpu datapath and its ALU.
package cpu_pkg;

    localparam int pDATA_WIDTH     = 8;
    localparam int pALU_FLAG_WIDTH = 4;
    localparam int pMEM_ADDR_WIDTH = 8;

    typedef struct packed {
        logic r0_en;
        logic r1_en;
        logic r2_en;
        logic r3_en;
        logic tmp_en;
        logic air_en;
        logic dir_en;
        logic ame_en;
        logic acc_en;
        logic flg_en;
        logic dme_en;
    } struct_reg_en_t;

    typedef enum logic [2:0] {
        DSEL_USR_0 = 3'd0,
        DSEL_USR_1 = 3'd1,
        DSEL_USR_2 = 3'd2,
        DSEL_USR_3 = 3'd3,
        DSEL_AIR   = 3'd4,
        DSEL_DME   = 3'd5,
        DSEL_ACC   = 3'd6
    } enum_dsel_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SHL = 3'd1,
        ALU_SHR = 3'd2,
        ALU_NOT = 3'd3,
        ALU_AND = 3'd4,
        ALU_OR  = 3'd5,
        ALU_XOR = 3'd6,
        ALU_CPR = 3'd7
    } enum_alu_opcode_t;

    typedef struct packed {
        logic c;
        logic a;
        logic e;
        logic z;
    } struct_alu_flag_t;

endpackage

// File: rtl/cpu_datapath_alu.sv
// Combinational ALU: A/B/carry-in and opcode to result plus {c,a,e,z} flags.
module cpu_alu
    import cpu_pkg::*;
(
    input  logic [pDATA_WIDTH-1:0] i_a,
    input  logic [pDATA_WIDTH-1:0] i_b,
    input  logic                   i_cin,
    input  enum_alu_opcode_t       i_opcode,
    output logic [pDATA_WIDTH-1:0] o_out,
    output struct_alu_flag_t       o_flag
);

    logic [pDATA_WIDTH:0]   w_sum;
    logic [pDATA_WIDTH-1:0] w_out;
    logic                   w_cout;

    // Operation select; only add and shifts produce a carry out
    always_comb begin
        w_sum  = {1'b0, i_a} + {1'b0, i_b} + {{pDATA_WIDTH{1'b0}}, i_cin};
        w_out  = {pDATA_WIDTH{1'b0}};
        w_cout = 1'b0;
        case (i_opcode)
            ALU_ADD: begin
                w_out  = w_sum[pDATA_WIDTH-1:0];
                w_cout = w_sum[pDATA_WIDTH];
            end
            ALU_SHL: begin
                w_out  = {i_a[pDATA_WIDTH-2:0], i_cin};
                w_cout = i_a[pDATA_WIDTH-1];
            end
            ALU_SHR: begin
                w_out  = {i_cin, i_a[pDATA_WIDTH-1:1]};
                w_cout = i_a[0];
            end
            ALU_NOT: w_out = ~i_a;
            ALU_AND: w_out = i_a & i_b;
            ALU_OR:  w_out = i_a | i_b;
            ALU_XOR: w_out = i_a ^ i_b;
            ALU_CPR: w_out = i_a;
            default: w_out = {pDATA_WIDTH{1'b0}};
        endcase
    end

    // Flag generation from operands and result
    always_comb begin
        o_out    = w_out;
        o_flag.c = w_cout;
        o_flag.a = (i_a > i_b);
        o_flag.e = (i_a == i_b);
        o_flag.z = (w_out == {pDATA_WIDTH{1'b0}});
    end

endmodule

// File: rtl/cpu_datapath.sv
// CPU datapath: user regs, TMP/ACC/IAR/IR/MAR, flags, bus mux, ALU and data RAM.
// Optional macro CPU_DP_MEM_LOAD_EN adds an external RAM load port (imem_ld_*).
module cpu_datapath
    import cpu_pkg::*;
#(
    parameter int    pMEM_DEPTH     = 256,
    parameter string pMEM_INIT_FILE = ""
) (
    input  logic                        iclk,
    input  logic                        irst,
    input  struct_reg_en_t              ireg_en,
    input  enum_dsel_t                  idata_sel,
    input  enum_alu_opcode_t            ialu_opcode,
    input  logic                        iforce_rb,
    input  logic                        iflag_clf,
`ifdef CPU_DP_MEM_LOAD_EN
    input  logic                        imem_ld_we,
    input  logic [pMEM_ADDR_WIDTH-1:0]  imem_ld_addr,
    input  logic [pDATA_WIDTH-1:0]      imem_ld_data,
`endif
    output logic [pDATA_WIDTH-1:0]      odir_data,
    output struct_alu_flag_t            oalu_flag,
    output logic [pDATA_WIDTH-1:0]      obus
);

    logic [pDATA_WIDTH-1:0] r_r0, r_r1, r_r2, r_r3;
    logic [pDATA_WIDTH-1:0] r_tmp, r_acc, r_iar, r_ir, r_mar;
    struct_alu_flag_t       r_flag;
    logic [pDATA_WIDTH-1:0] r_mem [0:pMEM_DEPTH-1];

    logic [pDATA_WIDTH-1:0] w_bus;
    logic [pDATA_WIDTH-1:0] w_mem_rd;
    logic [pDATA_WIDTH-1:0] w_alu_b;
    logic                   w_alu_cin;
    logic [pDATA_WIDTH-1:0] w_alu_out;
    struct_alu_flag_t       w_alu_flag;

    assign w_mem_rd = r_mem[r_mar[pMEM_ADDR_WIDTH-1:0]];

    // Bus source mux
    always_comb begin
        w_bus = {pDATA_WIDTH{1'b0}};
        case (idata_sel)
            DSEL_USR_0: w_bus = r_r0;
            DSEL_USR_1: w_bus = r_r1;
            DSEL_USR_2: w_bus = r_r2;
            DSEL_USR_3: w_bus = r_r3;
            DSEL_AIR:   w_bus = r_iar;
            DSEL_DME:   w_bus = w_mem_rd;
            DSEL_ACC:   w_bus = r_acc;
            default:    w_bus = {pDATA_WIDTH{1'b0}};
        endcase
    end

    // B operand forced to 1 with carry suppressed for the IAR increment
    always_comb begin
        w_alu_b   = r_tmp;
        w_alu_cin = r_flag.c;
        if (iforce_rb) begin
            w_alu_b   = {{(pDATA_WIDTH-1){1'b0}}, 1'b1};
            w_alu_cin = 1'b0;
        end else begin
            w_alu_b   = r_tmp;
            w_alu_cin = r_flag.c;
        end
    end

    cpu_alu u_alu (
        .i_a      (w_bus),
        .i_b      (w_alu_b),
        .i_cin    (w_alu_cin),
        .i_opcode (ialu_opcode),
        .o_out    (w_alu_out),
        .o_flag   (w_alu_flag)
    );

    // Register captures from the bus; ACC alone takes the ALU result
    always_ff @(posedge iclk) begin
        if (irst) begin
            r_r0  <= {pDATA_WIDTH{1'b0}};
            r_r1  <= {pDATA_WIDTH{1'b0}};
            r_r2  <= {pDATA_WIDTH{1'b0}};
            r_r3  <= {pDATA_WIDTH{1'b0}};
            r_tmp <= {pDATA_WIDTH{1'b0}};
            r_acc <= {pDATA_WIDTH{1'b0}};
            r_iar <= {pDATA_WIDTH{1'b0}};
            r_ir  <= {pDATA_WIDTH{1'b0}};
            r_mar <= {pDATA_WIDTH{1'b0}};
        end else begin
            if (ireg_en.r0_en)  r_r0  <= w_bus;
            if (ireg_en.r1_en)  r_r1  <= w_bus;
            if (ireg_en.r2_en)  r_r2  <= w_bus;
            if (ireg_en.r3_en)  r_r3  <= w_bus;
            if (ireg_en.tmp_en) r_tmp <= w_bus;
            if (ireg_en.air_en) r_iar <= w_bus;
            if (ireg_en.dir_en) r_ir  <= w_bus;
            if (ireg_en.ame_en) r_mar <= w_bus;
            if (ireg_en.acc_en) r_acc <= w_alu_out;
        end
    end

    // Flag register: a flag load overrides a clear in the same cycle
    always_ff @(posedge iclk) begin
        if (irst) begin
            r_flag <= '0;
        end else if (ireg_en.flg_en) begin
            r_flag <= w_alu_flag;
        end else if (iflag_clf) begin
            r_flag <= '0;
        end else begin
            r_flag <= r_flag;
        end
    end

    // RAM write port; contents are never cleared by reset
    always_ff @(posedge iclk) begin
`ifdef CPU_DP_MEM_LOAD_EN
        if (imem_ld_we) begin
            r_mem[imem_ld_addr] <= imem_ld_data;
        end else if (!irst && ireg_en.dme_en) begin
            r_mem[r_mar[pMEM_ADDR_WIDTH-1:0]] <= w_bus;
        end
`else
        if (!irst && ireg_en.dme_en) begin
            r_mem[r_mar[pMEM_ADDR_WIDTH-1:0]] <= w_bus;
        end
`endif
    end

    assign odir_data = r_ir;
    assign oalu_flag = r_flag;
    assign obus      = w_bus;

endmodule

// File: tb/tb_cpu_datapath.sv
// Scoreboard bench for cpu_datapath: directed vectors, expectations queued, checked by a monitor.
module tb_cpu_datapath;
    import cpu_pkg::*;

    localparam logic [10:0] M_R0  = 11'b100_0000_0000;
    localparam logic [10:0] M_R1  = 11'b010_0000_0000;
    localparam logic [10:0] M_R2  = 11'b001_0000_0000;
    localparam logic [10:0] M_R3  = 11'b000_1000_0000;
    localparam logic [10:0] M_TMP = 11'b000_0100_0000;
    localparam logic [10:0] M_AIR = 11'b000_0010_0000;
    localparam logic [10:0] M_DIR = 11'b000_0001_0000;
    localparam logic [10:0] M_AME = 11'b000_0000_1000;
    localparam logic [10:0] M_ACC = 11'b000_0000_0100;
    localparam logic [10:0] M_FLG = 11'b000_0000_0010;
    localparam logic [10:0] M_DME = 11'b000_0000_0001;
    localparam logic [10:0] M_NONE = 11'b000_0000_0000;
    localparam int K_BUS = 0;
    localparam int K_DIR = 1;
    localparam int K_FLG = 2;

    logic             iclk = 1'b0;
    logic             irst;
    struct_reg_en_t   ireg_en;
    enum_dsel_t       idata_sel;
    enum_alu_opcode_t ialu_opcode;
    logic             iforce_rb;
    logic             iflag_clf;
    logic [7:0]       odir_data;
    struct_alu_flag_t oalu_flag;
    logic [7:0]       obus;
`ifdef CPU_DP_MEM_LOAD_EN
    logic             imem_ld_we = 1'b0;
    logic [7:0]       imem_ld_addr = 8'h00;
    logic [7:0]       imem_ld_data = 8'h00;
`endif

    cpu_datapath dut (
        .iclk        (iclk),
        .irst        (irst),
        .ireg_en     (ireg_en),
        .idata_sel   (idata_sel),
        .ialu_opcode (ialu_opcode),
        .iforce_rb   (iforce_rb),
        .iflag_clf   (iflag_clf),
`ifdef CPU_DP_MEM_LOAD_EN
        .imem_ld_we  (imem_ld_we),
        .imem_ld_addr(imem_ld_addr),
        .imem_ld_data(imem_ld_data),
`endif
        .odir_data   (odir_data),
        .oalu_flag   (oalu_flag),
        .obus        (obus)
    );

    always #5 iclk = ~iclk;

    typedef struct {
        int         due;
        int         kind;
        string      name;
        logic [7:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    bit   drain_req = 1'b0;

    always @(posedge iclk) cyc <= cyc + 1;

    // Monitor: compares every expectation whose sample cycle has arrived
    always @(negedge iclk) begin : mon
        exp_t       e;
        logic [7:0] act;
        while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            e = sb_q.pop_front();
            case (e.kind)
                K_BUS:   act = obus;
                K_DIR:   act = odir_data;
                default: act = {4'h0, oalu_flag};
            endcase
            n_checks++;
            if (act !== e.val) begin
                n_fail++;
                $display("FAIL %s actual=0x%02h expected=0x%02h (cycle %0d)", e.name, act, e.val, cyc);
            end
        end
        if (drain_req) begin
            drain_req = 1'b0;
            n_checks++;
            if (sb_q.size() != 0) begin
                n_fail++;
                $display("FAIL drain actual=%0d pending expected=0 pending", sb_q.size());
            end
        end
    end

    task automatic expect_v(input int kind, input string name, input logic [7:0] val);
        exp_t e;
        e.due  = cyc;
        e.kind = kind;
        e.name = name;
        e.val  = val;
        sb_q.push_back(e);
    endtask

    task automatic drive(input enum_dsel_t sel, input enum_alu_opcode_t op, input logic [10:0] en,
                         input logic frb = 1'b0, input logic clf = 1'b0, input logic rst = 1'b0);
        idata_sel   = sel;
        ialu_opcode = op;
        ireg_en     = struct_reg_en_t'(en);
        iforce_rb   = frb;
        iflag_clf   = clf;
        irst        = rst;
        @(posedge iclk);
        #1;
    endtask

    task automatic chk_bus(input enum_dsel_t sel, input string name, input logic [7:0] val);
        expect_v(K_BUS, name, val);
        drive(sel, ALU_CPR, M_NONE);
    endtask

    // ACC <= v by clearing it (ACC ^ copy-of-ACC) then incrementing v times; clobbers TMP
    task automatic set_acc(input int v);
        drive(DSEL_ACC, ALU_CPR, M_TMP);
        drive(DSEL_ACC, ALU_XOR, M_ACC);
        for (int i = 0; i < v; i++) drive(DSEL_ACC, ALU_ADD, M_ACC, 1'b1);
    endtask

    task automatic load_reg(input int v, input logic [10:0] mask);
        set_acc(v);
        drive(DSEL_ACC, ALU_CPR, mask);
    endtask

    task automatic chk_all_zero(input string tag);
        chk_bus(DSEL_USR_0, {tag, "_r0"}, 8'h00);
        chk_bus(DSEL_USR_1, {tag, "_r1"}, 8'h00);
        chk_bus(DSEL_USR_2, {tag, "_r2"}, 8'h00);
        chk_bus(DSEL_USR_3, {tag, "_r3"}, 8'h00);
        chk_bus(DSEL_AIR,   {tag, "_iar"}, 8'h00);
        chk_bus(DSEL_ACC,   {tag, "_acc"}, 8'h00);
        expect_v(K_DIR, {tag, "_dir"}, 8'h00);
        expect_v(K_FLG, {tag, "_flg"}, 8'h00);
        drive(DSEL_ACC, ALU_CPR, M_NONE);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        enum_alu_opcode_t ops[5] = '{ALU_AND, ALU_OR, ALU_XOR, ALU_NOT, ALU_SHR};
        logic [7:0]       res[5] = '{8'h05, 8'hAF, 8'hAA, 8'h5A, 8'h52};
        idata_sel = DSEL_ACC; ialu_opcode = ALU_CPR; ireg_en = '0;
        iforce_rb = 1'b0; iflag_clf = 1'b0; irst = 1'b1;
        @(posedge iclk); #1;
        drive(DSEL_ACC, ALU_CPR, M_NONE, 1'b0, 1'b0, 1'b1);
        chk_all_zero("rst0");

        // Build state, then reset with every enable high
        set_acc(8'h10); drive(DSEL_ACC, ALU_CPR, M_AME);
        set_acc(8'h5A); drive(DSEL_ACC, ALU_CPR, M_DME);
        chk_bus(DSEL_DME, "ram10_pre", 8'h5A);
        load_reg(8'h77, M_R0);
        drive(DSEL_ACC, ALU_CPR, M_FLG);
        expect_v(K_FLG, "flag_pre", 8'h04);
        drive(DSEL_ACC, ALU_CPR, M_DIR | M_AIR);
        drive(DSEL_USR_0, ALU_ADD, 11'h7FF, 1'b0, 1'b0, 1'b1);
        chk_all_zero("rst1");
        set_acc(8'h10); drive(DSEL_ACC, ALU_CPR, M_AME);
        chk_bus(DSEL_DME, "ram10_kept", 8'h5A);

        // IAR increment into ACC with MAR capture, flags untouched
        set_acc(8'h0F); drive(DSEL_ACC, ALU_CPR, M_AME);
        set_acc(8'hC3); drive(DSEL_ACC, ALU_CPR, M_DME);
        set_acc(8'h10); drive(DSEL_ACC, ALU_CPR, M_AME);
        set_acc(8'h0F); drive(DSEL_ACC, ALU_CPR, M_AIR);
        drive(DSEL_ACC, ALU_CPR, M_NONE, 1'b0, 1'b1);
        drive(DSEL_AIR, ALU_ADD, M_ACC | M_AME, 1'b1);
        expect_v(K_FLG, "t2_flags", 8'h00);
        chk_bus(DSEL_ACC, "t2_acc", 8'h10);
        chk_bus(DSEL_DME, "t2_mar", 8'hC3);
        chk_bus(DSEL_AIR, "t2_iar", 8'h0F);

        // 0x01 + 0xFF wraps to zero with carry
        load_reg(8'h01, M_R0);
        load_reg(8'hFF, M_R1);
        drive(DSEL_USR_1, ALU_CPR, M_TMP);
        drive(DSEL_ACC, ALU_CPR, M_NONE, 1'b0, 1'b1);
        drive(DSEL_USR_0, ALU_ADD, M_ACC | M_FLG);
        expect_v(K_FLG, "t3_flags", 8'h09);
        chk_bus(DSEL_ACC, "t3_acc", 8'h00);

        // SHL with carry in, then flag load beats clear
        load_reg(8'h80, M_R2);
        drive(DSEL_USR_2, ALU_SHL, M_ACC | M_FLG);
        expect_v(K_FLG, "t4_flags", 8'h0C);
        chk_bus(DSEL_ACC, "t4_acc", 8'h01);
        drive(DSEL_USR_0, ALU_CPR, M_FLG, 1'b0, 1'b1);
        expect_v(K_FLG, "t4_flg_wins", 8'h04);
        drive(DSEL_ACC, ALU_CPR, M_NONE, 1'b0, 1'b1);
        expect_v(K_FLG, "t4_clf", 8'h00);

        // RAM write/read and IR load, then multi-enable capture
        load_reg(8'hA5, M_R2);
        set_acc(8'h20); drive(DSEL_ACC, ALU_CPR, M_AME);
        drive(DSEL_USR_2, ALU_CPR, M_DME);
        chk_bus(DSEL_DME, "t5_ram", 8'hA5);
        drive(DSEL_DME, ALU_CPR, M_DIR);
        expect_v(K_DIR, "t5_dir", 8'hA5);
        drive(DSEL_USR_2, ALU_CPR, M_R0 | M_R3 | M_AIR);
        chk_bus(DSEL_USR_0, "multi_r0", 8'hA5);
        chk_bus(DSEL_USR_3, "multi_r3", 8'hA5);
        chk_bus(DSEL_AIR,   "multi_iar", 8'hA5);

        // Logic ops with A=0xA5, B=0x0F, carry clear
        load_reg(8'h0F, M_R3);
        drive(DSEL_USR_3, ALU_CPR, M_TMP);
        drive(DSEL_ACC, ALU_CPR, M_NONE, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            drive(DSEL_USR_2, ops[i], M_ACC);
            chk_bus(DSEL_ACC, $sformatf("op_%s", ops[i].name()), res[i]);
        end
        drive(DSEL_USR_3, ALU_CPR, M_FLG);
        expect_v(K_FLG, "cpr_eq_flags", 8'h02);
        drive(DSEL_USR_2, ALU_SHR, M_FLG);
        expect_v(K_FLG, "shr_flags", 8'h0C);
        drive(DSEL_USR_3, ALU_ADD, M_ACC);
        chk_bus(DSEL_ACC, "add_cin", 8'h1F);

`ifdef CPU_DP_MEM_LOAD_EN
        load_reg(8'h22, M_R0);
        imem_ld_we = 1'b1; imem_ld_addr = 8'h20; imem_ld_data = 8'h11;
        drive(DSEL_USR_0, ALU_CPR, M_DME);
        imem_ld_we = 1'b0;
        chk_bus(DSEL_DME, "ld_priority", 8'h11);
`endif

        drive(DSEL_ACC, ALU_CPR, M_NONE);
        for (int i = 0; i < 10 && sb_q.size() != 0; i++) drive(DSEL_ACC, ALU_CPR, M_NONE);
        drain_req = 1'b1;
        drive(DSEL_ACC, ALU_CPR, M_NONE);
        drive(DSEL_ACC, ALU_CPR, M_NONE);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
